buffer_pick_engine: RTL and testbench
=====================================

# buffer_pick_engine

- Sequential successor to the single-shot buffer mapper.
- Accepts a candidate bitmap of BS buffers and a pick count, then draws up to NUM_PICKS distinct buffer indices without replacement. Each draw uses one random word from the ESM random source.
- Picks are returned one per beat over a valid/ready stream.
- Sits between the candidate-generation logic and the buffer write-select path.

## Interface
- BS, 16, number of buffers (≥2, power of two); RW = $clog2(BS)
- PICKS, 4, maximum picks per request (1..BS); PW = $clog2(PICKS+1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  engine idle, request accepted when both high
- candidate_list  in  BS  bit i set = buffer i eligible
- num_picks  in  PW  picks requested; values >PICKS clipped to PICKS
- rand_valid  in  1  random word offered
- rand_ready  out  1  engine consumes random word
- rand_data  in  RW  random word
- out_valid  out  1  pick beat valid
- out_ready  in  1  downstream accepts beat
- out_index  out  RW  selected buffer index
- out_none  out  1  no candidates in request (index meaningless, =0)
- out_last  out  1  final beat of this request

## Operation
- FSM states: IDLE, LOAD, RAND, REDUCE, EMIT.
- IDLE
  - req_ready = 1.
  - On handshake: register candidate_list and clipped num_picks, then go to LOAD.
- LOAD (1 cycle)
  - Compaction: table[k] = k-th set bit counting from bit 0 upward; count = popcount (RW+1 bits).
  - remaining = min(picks, count).
  - count==0 → EMIT with out_none=1, out_last=1.
  - remaining==0 (zero picks requested) → IDLE, no beat emitted.
  - Otherwise → RAND.
- RAND
  - rand_ready = 1.
  - On handshake: r ← rand_data, then go to REDUCE.
- REDUCE: modulo by repeated subtraction, one step per cycle.
  - If r ≥ count: r ← r − count.
  - Else: latch out_index = table[r] and go to EMIT.
  - No divider.
- EMIT
  - out_valid = 1; out_index, out_none and out_last held stable until out_ready.
  - out_last = (remaining==1) or out_none.
  - On handshake (normal beat): remove table[r] by shifting entries r+1..count−1 down one; count−1; remaining−1. Next state is IDLE if remaining becomes 0, else RAND.
  - On handshake (none beat): next state is IDLE.
- Picks within one request are always distinct. A random word is consumed only in RAND.
- rand_ready is 0 outside RAND; out_valid is 0 outside EMIT; req_ready is 0 outside IDLE.

## Timing
- Reset
  - rst high at an edge forces IDLE from any state and clears all registers (table, count, remaining, r).
  - While rst is high: req_ready=0, rand_ready=0, out_valid=0, out_index=0, out_none=0, out_last=0.
  - req_ready=1 combinationally once rst is low in IDLE.
- Request-to-first-beat latency (instant random source, r<count): 4 cycles.
  - Handshake at edge T; LOAD in cycle T+1; RAND in T+2; REDUCE in T+3; out_valid in T+4.
- Each extra REDUCE step adds 1 cycle. Worst case floor((BS−1)/1) steps at count=1.
- Between picks: EMIT accept → RAND next cycle; a new beat arrives at minimum 3 cycles after the previous accept.
- Back-to-back requests: accept of the final beat → IDLE next cycle → req_ready=1 that cycle.
- Empty request: beat is valid 2 cycles after acceptance; no random word is consumed.

## Structure
- Shared package `esm_sel_pkg`:
  - FSM state encoding constants (IDLE..EMIT).
  - Width helper functions RW/PW.
- Sub-module `candidate_compactor`: combinational bitmap → compacted table + popcount, parametrised by BS. Its output is registered in LOAD by this block.
- The remove-and-shift operation stays in this block.

## Test plan
- BS=16, list bits {2,5,7}, num_picks=1, rand=4:
  - count=3; one REDUCE subtraction (4→1).
  - out_index=5, out_last=1, out_none=0.
  - First out_valid is 5 cycles after the request handshake.
- Same list, num_picks=3, rand 0,0,0: beats 2,5,7 in that order; out_last only on the third; exactly 3 rand handshakes.
- Empty list, num_picks=2: single beat with out_none=1, out_last=1, out_index=0; rand_ready never asserted.
- List {0,15}, num_picks=4, rand 15 then 15:
  - First beat index 15 (15 mod 2 = 1).
  - Second beat index 0, with out_last=1.
  - Only 2 rand handshakes.
- out_ready held low 5 cycles in EMIT: out_valid, out_index and out_last stable; rand_ready=0 throughout; the beat completes when out_ready rises.
- rst pulsed for 1 cycle during REDUCE:
  - All outputs 0 next cycle; the pending beat is never emitted.
  - req_ready=1 after rst falls; a subsequent request ({3}, picks=1, rand=9) returns index 3.

Source files
------------

// File: rtl/esm_sel_pkg.sv
// Shared definitions for the ESM buffer-selection blocks: FSM state encoding
// and the width helpers used to size index and pick-count fields.
package esm_sel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RAND   = 3'd2,
    ST_REDUCE = 3'd3,
    ST_EMIT   = 3'd4
  } selState_t;

  // Bits needed to index one of bs buffers.
  function automatic int calcRw(input int bs);
    return $clog2(bs);
  endfunction

  // Bits needed to hold a pick count from 0 up to picks inclusive.
  function automatic int calcPw(input int picks);
    return $clog2(picks + 1);
  endfunction

endpackage

// File: rtl/buffer_pick_engine_compactor.sv
// Combinational bitmap compactor: entry k of the table is the index of the
// k-th set bit counting upward from bit 0, and the count is the popcount.
module candidate_compactor
  import esm_sel_pkg::*;
#(
  parameter  int BS = 16,
  localparam int RW = calcRw(BS),
  localparam int CW = RW + 1
) (
  input  logic [BS-1:0]         i_bitmap,
  output logic [BS-1:0][RW-1:0] o_table,
  output logic [CW-1:0]         o_count
);

  logic [CW-1:0] w_count;

  // Walk the bitmap from bit 0 upward, appending each set index to the table.
  always_comb begin
    o_table = '0;
    w_count = '0;
    for (int i = 0; i < BS; i++) begin
      if (i_bitmap[i]) begin
        o_table[w_count[RW-1:0]] = RW'(i);
        w_count = w_count + CW'(1);
      end
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/buffer_pick_engine.sv
// Sequential buffer pick engine: draws up to PICKS distinct buffers from a
// candidate bitmap, one random word per draw, reducing each word modulo the
// remaining candidate count by repeated subtraction.
module buffer_pick_engine
  import esm_sel_pkg::*;
#(
  parameter  int BS    = 16,
  parameter  int PICKS = 4,
  localparam int RW    = calcRw(BS),
  localparam int PW    = calcPw(PICKS),
  localparam int CW    = RW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [BS-1:0] candidate_list,
  input  logic [PW-1:0] num_picks,
  input  logic          rand_valid,
  output logic          rand_ready,
  input  logic [RW-1:0] rand_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_index,
  output logic          out_none,
  output logic          out_last
);

  selState_t             r_state;
  selState_t             w_nextState;
  logic [BS-1:0]         r_cand;
  logic [PW-1:0]         r_picks;
  logic [PW-1:0]         r_remaining;
  logic [BS-1:0][RW-1:0] r_table;
  logic [BS-1:0][RW-1:0] w_table;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count;
  logic [RW-1:0]         r_rand;
  logic [RW-1:0]         r_outIndex;
  logic                  r_outNone;
  logic [PW-1:0]         w_clipped;
  logic [PW-1:0]         w_loadRemaining;
  logic                  w_reduceDone;
  logic                  w_lastBeat;

  candidate_compactor #(.BS(BS)) uCompactor (
    .i_bitmap (r_cand),
    .o_table  (w_table),
    .o_count  (w_count)
  );

  assign w_clipped       = (int'(num_picks) > PICKS) ? PW'(PICKS) : num_picks;
  assign w_loadRemaining = (int'(r_picks) < int'(w_count)) ? r_picks : PW'(w_count);
  assign w_reduceDone    = (CW'(r_rand) < r_count);
  assign w_lastBeat      = r_outNone || (r_remaining == PW'(1));

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection from the current state and the three handshakes.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_nextState = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_count == '0)              w_nextState = ST_EMIT;
        else if (w_loadRemaining == '0) w_nextState = ST_IDLE;
        else                            w_nextState = ST_RAND;
      end
      ST_RAND: begin
        if (rand_valid) w_nextState = ST_REDUCE;
      end
      ST_REDUCE: begin
        if (w_reduceDone) w_nextState = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) w_nextState = w_lastBeat ? ST_IDLE : ST_RAND;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    req_ready  = 1'b0;
    rand_ready = 1'b0;
    out_valid  = 1'b0;
    out_index  = '0;
    out_none   = 1'b0;
    out_last   = 1'b0;
    if (!rst) begin
      req_ready  = (r_state == ST_IDLE);
      rand_ready = (r_state == ST_RAND);
      out_valid  = (r_state == ST_EMIT);
      if (r_state == ST_EMIT) begin
        out_index = r_outIndex;
        out_none  = r_outNone;
        out_last  = w_lastBeat;
      end
    end
  end

  // Datapath: capture the request, snapshot the compacted table, reduce the
  // random word, and on each accepted beat close the gap left by the pick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand      <= '0;
      r_picks     <= '0;
      r_remaining <= '0;
      r_table     <= '0;
      r_count     <= '0;
      r_rand      <= '0;
      r_outIndex  <= '0;
      r_outNone   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cand    <= candidate_list;
            r_picks   <= w_clipped;
            r_outNone <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_table     <= w_table;
          r_count     <= w_count;
          r_remaining <= w_loadRemaining;
          r_rand      <= '0;
          r_outIndex  <= '0;
          r_outNone   <= (w_count == '0);
        end
        ST_RAND: begin
          if (rand_valid) r_rand <= rand_data;
        end
        ST_REDUCE: begin
          if (!w_reduceDone) r_rand     <= r_rand - r_count[RW-1:0];
          else               r_outIndex <= r_table[r_rand];
        end
        ST_EMIT: begin
          if (out_ready && !r_outNone) begin
            for (int k = 0; k < BS - 1; k++) begin
              if (k >= int'(r_rand)) r_table[k] <= r_table[k+1];
            end
            r_table[BS-1] <= '0;
            r_count       <= r_count - CW'(1);
            r_remaining   <= r_remaining - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_pick_engine.sv
// Self-checking bench for buffer_pick_engine. A queue of candidate indices
// models the draw-without-replacement behaviour; each random word selects
// entry (word mod size) and removes it, and the expected beat timing is
// derived from the number of subtraction steps the word implies.
module tb_buffer_pick_engine;

  localparam int BS    = 16;
  localparam int PICKS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] candidate_list;
  logic [2:0]  num_picks;
  logic        rand_valid;
  logic        rand_ready;
  logic [3:0]  rand_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_none;
  logic        out_last;

  int randWords [16];
  int holdCycles;
  int nChecks;
  int nFails;

  buffer_pick_engine #(.BS(BS), .PICKS(PICKS)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .candidate_list (candidate_list),
    .num_picks      (num_picks),
    .rand_valid     (rand_valid),
    .rand_ready     (rand_ready),
    .rand_data      (rand_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .out_none       (out_none),
    .out_last       (out_last)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and follows it to completion, checking every cycle.
  task automatic applyStimulus(input logic [15:0] list, input int picks, input bit randomFlow);
    int  q[$];
    int  clipped, remain, initRemain, edgeCnt, randIdx, pendIdx, pendSlot;
    int  validEdge, randStartEdge, holdLeft, randShakes, word;
    bit  none, havePending, done, expVal, expRandReady;

    q = {};
    for (int i = 0; i < BS; i++) if (list[i]) q.push_back(i);
    clipped     = (picks > PICKS) ? PICKS : picks;
    remain      = (clipped < q.size()) ? clipped : q.size();
    initRemain  = remain;
    none        = (q.size() == 0);
    randIdx     = 0;
    pendIdx     = 0;
    pendSlot    = 0;
    validEdge   = 0;
    randStartEdge = 2;
    havePending = 1'b0;
    done        = 1'b0;
    holdLeft    = holdCycles;
    randShakes  = 0;

    checkOutput("req_ready_idle", req_ready, 1);
    req_valid      = 1'b1;
    candidate_list = list;
    num_picks      = picks[2:0];
    stepCycle();
    req_valid      = 1'b0;
    candidate_list = 16'($urandom);
    num_picks      = 3'($urandom);
    edgeCnt        = 1;

    while (!done && edgeCnt < 600) begin
      expVal       = (none && edgeCnt >= 2) || (havePending && edgeCnt >= validEdge);
      expRandReady = !none && (remain > 0) && !havePending && (edgeCnt >= randStartEdge);
      checkOutput("out_valid", out_valid, expVal);
      checkOutput("rand_ready", rand_ready, expRandReady);
      checkOutput("req_ready_busy", req_ready, (!none && initRemain == 0 && edgeCnt >= 2));

      if (!none && initRemain == 0 && edgeCnt >= 2) done = 1'b1;

      rand_data  = 4'($urandom);
      rand_valid = 1'b0;
      if (rand_ready) begin
        word       = randWords[randIdx % 16];
        rand_data  = word[3:0];
        rand_valid = randomFlow ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rand_valid && q.size() > 0) begin
          randShakes++;
          randIdx++;
          pendSlot    = word % q.size();
          pendIdx     = q[pendSlot];
          havePending = 1'b1;
          validEdge   = edgeCnt + 2 + word / q.size();
        end
      end

      out_ready = 1'b0;
      if (expVal) begin
        checkOutput("out_index", out_index, none ? 0 : pendIdx);
        checkOutput("out_last", out_last, (none || remain == 1));
        checkOutput("out_none", out_none, none);
        if (holdLeft > 0) begin
          holdLeft--;
        end else begin
          out_ready = randomFlow ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          if (none) begin
            done = 1'b1;
          end else begin
            q.delete(pendSlot);
            remain--;
            havePending   = 1'b0;
            holdLeft      = holdCycles;
            randStartEdge = edgeCnt + 1;
            if (remain == 0) done = 1'b1;
          end
        end
      end

      stepCycle();
      edgeCnt++;
      rand_valid = 1'b0;
      out_ready  = 1'b0;
    end

    if (!done) checkOutput("timeout", 0, 1);
    checkOutput("req_ready_after", req_ready, 1);
    checkOutput("out_valid_after", out_valid, 0);
    checkOutput("rand_handshakes", randShakes, none ? 0 : initRemain);
  endtask

  initial begin
    nChecks        = 0;
    nFails         = 0;
    holdCycles     = 0;
    rst            = 1'b1;
    req_valid      = 1'b0;
    candidate_list = '0;
    num_picks      = '0;
    rand_valid     = 1'b0;
    rand_data      = '0;
    out_ready      = 1'b0;
    foreach (randWords[i]) randWords[i] = 0;

    repeat (3) stepCycle();
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rand_ready", rand_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_index", out_index, 0);
    checkOutput("rst_out_none", out_none, 0);
    checkOutput("rst_out_last", out_last, 0);
    rst = 1'b0;
    #1;
    checkOutput("req_ready_post_rst", req_ready, 1);
    stepCycle();

    // Single pick from {2,5,7} with word 4: one subtraction, index 5.
    randWords[0] = 4;
    applyStimulus(16'h00A4, 1, 1'b0);

    // Three picks with words 0,0,0 drain the list in ascending order.
    randWords[0] = 0; randWords[1] = 0; randWords[2] = 0;
    applyStimulus(16'h00A4, 3, 1'b0);

    // Empty list produces one none beat and consumes no random word.
    applyStimulus(16'h0000, 2, 1'b0);

    // {0,15} with words 15,15: index 15 then index 0.
    randWords[0] = 15; randWords[1] = 15;
    applyStimulus(16'h8001, 4, 1'b0);

    // Downstream stalls each beat for 5 cycles.
    holdCycles   = 5;
    randWords[0] = 0; randWords[1] = 1;
    applyStimulus(16'h00A4, 2, 1'b0);
    holdCycles   = 0;

    // Zero picks requested: straight back to idle.
    applyStimulus(16'h00A4, 0, 1'b0);

    // Oversized pick count is clipped to the maximum.
    foreach (randWords[i]) randWords[i] = $urandom_range(0, 15);
    applyStimulus(16'hFFFF, 7, 1'b0);

    // Reset pulse while reducing a word that needs several subtractions.
    req_valid      = 1'b1;
    candidate_list = 16'h00A4;
    num_picks      = 3'd1;
    stepCycle();
    req_valid      = 1'b0;
    stepCycle();
    rand_valid     = 1'b1;
    rand_data      = 4'd15;
    stepCycle();
    rand_valid     = 1'b0;
    rst            = 1'b1;
    stepCycle();
    checkOutput("midrst_req_ready", req_ready, 0);
    checkOutput("midrst_rand_ready", rand_ready, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_index", out_index, 0);
    checkOutput("midrst_out_none", out_none, 0);
    checkOutput("midrst_out_last", out_last, 0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_req_ready_after", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("midrst_no_beat", out_valid, 0);
    end
    randWords[0] = 9;
    applyStimulus(16'h0008, 1, 1'b0);

    // Randomised requests with random handshake timing on both streams.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] list;
      int          sel;
      sel  = $urandom_range(0, 3);
      list = 16'($urandom);
      if (sel == 0)      list = '0;
      else if (sel == 1) list = list & 16'($urandom) & 16'($urandom);
      foreach (randWords[i]) randWords[i] = $urandom_range(0, 15);
      applyStimulus(list, $urandom_range(0, 7), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
